// File: rtl/obstacle_lane_ctrl.sv
// Obstacle lane controller: picks per-wrap obstacle patterns from an LFSR,
// qualifies collision windows against the player lane, and tracks lives/score/state.
module obstacle_lane_ctrl #(
    parameter int         LIVES_INIT = 3,
    parameter logic [7:0] LFSR_SEED  = 8'hA5,
    parameter int         SCORE_MAX  = 999,
    parameter int         INV_WRAPS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] car_lane,
    input  logic       on_collision,
    input  logic       wrap_pos,
    output logic [3:0] lane_en,
    output logic [1:0] lives,
    output logic [9:0] score,
    output logic       hit,
    output logic       game_over,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_INVUL = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    state_t     st, st_nx;
    logic       start_q, coll_q, wrap_q;
    logic       rise_start, rise_coll, rise_wrap;
    logic [1:0] lane_q;
    logic [7:0] lfsr;
    logic [3:0] pat;
    logic [1:0] inv_cnt, inv_cnt_nx;
    logic [3:0] lane_en_nx;
    logic [1:0] lives_nx;
    logic [9:0] score_nx;
    logic       hit_nx;
    logic       is_hit;

    // Edge stage: rising edges are captured into registers so every input
    // event reaches the outputs exactly two cycles after it is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            coll_q     <= 1'b0;
            wrap_q     <= 1'b0;
            rise_start <= 1'b0;
            rise_coll  <= 1'b0;
            rise_wrap  <= 1'b0;
            lane_q     <= 2'd0;
        end else begin
            start_q    <= start;
            coll_q     <= on_collision;
            wrap_q     <= wrap_pos;
            rise_start <= start & ~start_q;
            rise_coll  <= on_collision & ~coll_q;
            rise_wrap  <= wrap_pos & ~wrap_q;
            lane_q     <= car_lane;
        end
    end

    // Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Forces at least one free and one blocked lane.
    always_comb begin
        pat = lfsr[3:0];
        if (lfsr[3:0] == 4'hF)      pat[lfsr[5:4]] = 1'b0;
        else if (lfsr[3:0] == 4'h0) pat[lfsr[5:4]] = 1'b1;
    end

    assign is_hit = rise_coll & lane_en[lane_q];

    always_comb begin
        st_nx      = st;
        lane_en_nx = lane_en;
        lives_nx   = lives;
        score_nx   = score;
        inv_cnt_nx = inv_cnt;
        hit_nx     = 1'b0;
        case (st)
            S_IDLE, S_OVER: begin
                lane_en_nx = 4'd0;
                if (rise_start) begin
                    st_nx      = S_RUN;
                    lives_nx   = 2'(LIVES_INIT);
                    score_nx   = 10'd0;
                    lane_en_nx = pat;
                end
            end
            S_RUN: begin
                if (rise_wrap) lane_en_nx = pat;
                if (is_hit) begin
                    hit_nx = 1'b1;
                    if (lives == 2'd1) begin
                        st_nx      = S_OVER;
                        lives_nx   = 2'd0;
                        lane_en_nx = 4'd0;
                    end else begin
                        st_nx      = S_INVUL;
                        lives_nx   = lives - 2'd1;
                        inv_cnt_nx = 2'(INV_WRAPS);
                    end
                end else if (rise_wrap && score < 10'(SCORE_MAX)) begin
                    score_nx = score + 10'd1;
                end
            end
            S_INVUL: begin
                if (rise_wrap) begin
                    lane_en_nx = pat;
                    inv_cnt_nx = inv_cnt - 2'd1;
                    if (inv_cnt == 2'd1) st_nx = S_RUN;
                end
            end
            default: st_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_IDLE;
            lane_en <= 4'd0;
            lives   <= 2'd0;
            score   <= 10'd0;
            inv_cnt <= 2'd0;
            hit     <= 1'b0;
        end else begin
            st      <= st_nx;
            lane_en <= lane_en_nx;
            lives   <= lives_nx;
            score   <= score_nx;
            inv_cnt <= inv_cnt_nx;
            hit     <= hit_nx;
        end
    end

    assign state     = st;
    assign game_over = (st == S_OVER);

endmodule

// File: tb/tb_obstacle_lane_ctrl.sv
// Scoreboard bench for obstacle_lane_ctrl: stimulus pushes time-stamped expectations,
// a monitor pops and compares them one cycle-sample at a time.
module tb_obstacle_lane_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, on_collision = 1'b0, wrap_pos = 1'b0;
    logic [1:0] car_lane = 2'd0;
    logic [3:0] lane_en;
    logic [1:0] lives, state;
    logic [9:0] score;
    logic       hit, game_over;

    obstacle_lane_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .car_lane(car_lane),
        .on_collision(on_collision), .wrap_pos(wrap_pos), .lane_en(lane_en),
        .lives(lives), .score(score), .hit(hit), .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [1:0] lv;
        logic [9:0] sc;
        logic       hit;
        logic       ld;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0, cyc = 0;
    logic [7:0] m_lfsr, m_prev;
    logic [3:0] m_lane = 4'd0;
    int   ms = 0, ml = 0, msc = 0, mcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [3:0] pat(input logic [7:0] l);
        logic [3:0] r;
        r = l[3:0];
        if (r == 4'hF)      r[l[5:4]] = 1'b0;
        else if (r == 4'h0) r[l[5:4]] = 1'b1;
        return r;
    endfunction

    function automatic logic [1:0] lane_blk(input logic [3:0] m);
        for (int i = 3; i >= 0; i--) if (m[i]) lane_blk = 2'(i);
    endfunction

    function automatic logic [1:0] lane_free(input logic [3:0] m);
        for (int i = 3; i >= 0; i--) if (!m[i]) lane_free = 2'(i);
    endfunction

    // Reference LFSR; m_prev is the value the DUT used at the last edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= step(m_lfsr);
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, x);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic [3:0] el;
        logic ok;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.ld)                     el = pat(m_prev);
                else if (e.st == 0 || e.st == 3) el = 4'd0;
                else                          el = m_lane;
                ok = (cyc == e.cyc) && (state === e.st) && (lives === e.lv) &&
                     (score === e.sc) && (hit === e.hit) &&
                     (game_over === (e.st == 2'd3)) && (lane_en === el);
                if (e.st == 2'd1 || e.st == 2'd2)
                    ok = ok && (lane_en != 4'h0) && (lane_en != 4'hF);
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL scb@%0d: got st=%0d lv=%0d sc=%0d hit=%0b go=%0b lane=%b, expected st=%0d lv=%0d sc=%0d hit=%0b lane=%b at cyc %0d",
                             cyc, state, lives, score, hit, game_over, lane_en,
                             e.st, e.lv, e.sc, e.hit, el, e.cyc);
                end
                if (e.ld) m_lane = el;
            end
        end
    end

    // Apply one input event, update the model, push expectations.
    task automatic ev(input bit s, input bit c, input bit w, input logic [1:0] lane, input int hold);
        int base;
        bit hit_e, ld;
        exp_t e;
        @(negedge clk);
        base = cyc;
        car_lane = lane; start = s; on_collision = c; wrap_pos = w;
        hit_e = 0; ld = 0;
        case (ms)
            0, 3: if (s) begin ms = 1; ml = 3; msc = 0; ld = 1; end
            1: begin
                if (w) ld = 1;
                if (c && m_lane[lane]) begin
                    hit_e = 1;
                    if (ml == 1) begin ms = 3; ml = 0; ld = 0; end
                    else begin ml--; ms = 2; mcnt = 1; end
                end else if (w) msc = (msc < 999) ? msc + 1 : 999;
            end
            default: if (w) begin
                ld = 1;
                mcnt--;
                if (mcnt == 0) ms = 1;
            end
        endcase
        e = '{base + 2, 2'(ms), 2'(ml), 10'(msc), hit_e, ld};
        q.push_back(e);
        e = '{base + 3, 2'(ms), 2'(ml), 10'(msc), 1'b0, 1'b0};
        q.push_back(e);
        repeat (hold) @(negedge clk);
        start = 0; on_collision = 0; wrap_pos = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state), 0);
        chk("reset_outs", 32'({lane_en, lives, score, hit, game_over}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        ev(1, 0, 0, 0, 1);                      // start -> RUN
        ev(0, 1, 0, lane_blk(m_lane), 1);       // hit -> INVUL, lives 2
        ev(0, 1, 0, lane_blk(m_lane), 1);       // ignored in INVUL
        ev(0, 0, 1, 0, 1);                      // wrap -> RUN, no score
        ev(0, 1, 0, lane_free(m_lane), 100);    // held window on free lane
        ev(0, 0, 1, 0, 1);                      // score 1
        ev(1, 0, 0, 0, 1);                      // start ignored in RUN
        ev(0, 1, 1, lane_blk(m_lane), 1);       // hit beats wrap
        ev(0, 0, 1, 0, 1);
        ev(0, 1, 0, lane_blk(m_lane), 1);       // last life -> OVER
        ev(0, 0, 1, 0, 1);                      // wrap ignored in OVER
        ev(1, 0, 0, 0, 1);                      // restart
        repeat (1000) ev(0, 0, 1, 0, 1);        // score saturates at 999
        ev(0, 1, 1, lane_blk(m_lane), 1);       // hit+wrap at saturation

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_state", 32'(state), 0);
        chk("midrun_rst_outs", 32'({lane_en, lives, score, hit, game_over}), 0);
        ms = 0; ml = 0; msc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        ev(1, 0, 0, 0, 1);                      // start after reset
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/obstacle_lane_ctrl.md
Name: obstacle_lane_ctrl

Overview:
- Drives the obstacle renderer's four lane-enable inputs and consumes its status outputs.
  - Outputs: one enable per lane, laid out left to right.
  - Inputs consumed: the collision-window level and the position-wrap level.
- Picks a new pseudo-random obstacle pattern each time the obstacle row wraps off-screen.
- Decides whether a collision window is a real hit for the player's current lane, and tracks lives, score and game state.
- Sits between the renderer and the top-level game / score display.

Parameters:
- LIVES_INIT, 3, lives loaded on game start (1..3).
- LFSR_SEED, 8'hA5, LFSR value after reset; must be nonzero.
- SCORE_MAX, 999, score saturation value.
- INV_WRAPS, 1, wraps of invulnerability after a hit (1..3).

Ports:
- clk  in  1  system clock; all inputs synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  start/restart request, level; rising edge used.
- car_lane  in  2  player lane 0..3, left to right.
- on_collision  in  1  renderer collision-window level (obstacle row in car Y range).
- wrap_pos  in  1  renderer position-wrap level (obstacle row restarted at top).
- lane_en  out  4  obstacle lane enables; bit0 = leftmost lane.
- lives  out  2  remaining lives.
- score  out  10  obstacle rows survived, binary.
- hit  out  1  one-cycle pulse on a counted hit.
- game_over  out  1  high in OVER state.
- state  out  2  00 IDLE, 01 RUN, 10 INVUL, 11 OVER.

Behaviour:
- Reset (async, rst_n low) values:
  - state=IDLE, lane_en=0, lives=0, score=0, hit=0, game_over=0.
  - LFSR=LFSR_SEED; all edge-detect registers=0.
- Edge detection:
  - start, on_collision and wrap_pos are each registered once.
  - rise_x = x & ~x_q.
  - Only rising edges act; a level held high acts once.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every clk cycle in every state except during reset.
- Pattern generation on a load event. Let p = LFSR[3:0] and k = LFSR[5:4].
  - If p == 4'b1111, clear bit k.
  - If p == 4'b0000, set bit k.
  - Otherwise use p as-is.
  - Result: at least one lane is always free and at least one is always blocked.
- IDLE: lane_en=0. On rise_start → RUN; lives=LIVES_INIT; score=0; lane_en=new pattern.
- RUN:
  - rise_coll with lane_en[car_lane]==1 is a hit:
    - hit=1 for one cycle; lives decrements.
    - If lives was 1 → OVER, lives=0.
    - Otherwise → INVUL, with the invulnerability counter loaded to INV_WRAPS.
  - rise_coll with lane_en[car_lane]==0: no effect.
  - rise_wrap: score+1, saturating at SCORE_MAX; lane_en=new pattern.
  - rise_wrap and a hit in the same cycle: the hit wins; no score; the pattern is still reloaded.
- INVUL:
  - rise_coll is ignored.
  - rise_wrap: lane_en=new pattern, no score, counter decrements.
  - When the counter reaches 0 → RUN.
- OVER:
  - game_over=1; lane_en=0; score frozen.
  - rise_start → RUN with the same initialisation as from IDLE.
- rise_start while in RUN or INVUL: ignored.
- car_lane is sampled in the same cycle as rise_coll. No lane-change tracking inside the collision window.
- lane_en changes only on a load event, so obstacles never change mid-screen.
- Reset mid-game: immediate return to reset values; no pulse on hit.
- Latency:
  - Input edge to output change is 2 cycles: 1 cycle edge register, 1 cycle state/output register.
  - hit is registered.

Test Plan:
- Reset, then start pulse → after 2 cycles: state=01, lives=3, score=0, lane_en = pattern from the LFSR value at load, neither 0000 nor 1111.
- RUN with lane_en=4'b0010, car_lane=1, on_collision 0→1 → hit single-cycle pulse, lives 3→2, state=10. Further on_collision edge before a wrap → no hit, lives stays 2.
- RUN with lane_en=4'b0010, car_lane=2, on_collision held high for 100 cycles → no hit, lives unchanged. Then wrap_pos rise → score+1, lane_en reloaded.
- Three counted hits, each separated by a wrap → lives 3→2→1→0, game_over=1, state=11, lane_en=0. Start pulse → state=01, lives=3, score=0.
- Force score=998 via wraps; two more wraps → 999, 999 (saturates). Same-cycle rise_wrap and hit → score unchanged, lives-1.
- Sweep 1000 pattern loads → lane_en never 0000 or 1111. Assert rst_n low mid-RUN → all outputs zero immediately, asynchronously.
